// File: rtl/router_pkt_gen_if.sv
// Router-side bus of the packet generator: byte stream towards the router
// input port, per-channel read enables and the router's flow-control
// returns.
//   packet_valid  generator -> router  header/payload byte valid
//   data_out      generator -> router  byte presented to router datain
//   read_enb      generator -> router  per-channel read enable, one-hot or zero
//   busy          router -> generator  router cannot take a byte this edge
//   vld_out       router -> generator  per-channel output valid
interface router_pkt_gen_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 3
);
    logic              packet_valid;
    logic [DATA_W-1:0] data_out;
    logic [NUM_CH-1:0] read_enb;
    logic              busy;
    logic [NUM_CH-1:0] vld_out;

    modport master (
        output packet_valid,
        output data_out,
        output read_enb,
        input  busy,
        input  vld_out
    );

    modport slave (
        input  packet_valid,
        input  data_out,
        input  read_enb,
        output busy,
        output vld_out
    );
endinterface

// File: rtl/router_pkt_gen.sv
// Parametrised packet source for the 1xN router. A start command is turned
// into header {len,dest}, len payload bytes (LFSR or incrementing) and a
// parity byte. The generator honours router busy, then drains the target
// channel by holding its read enable until that channel's valid drops or a
// timeout expires.
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   start      command strobe, sampled in IDLE only
//   dest       target channel, captured with start
//   len        payload length in bytes, captured with start
//   mode       payload source: 0 = LFSR, 1 = incrementing from 0
//   inj_err    invert the parity byte, captured with start
//   rtr        router-side bus (packet_valid, data_out, read_enb, busy, vld_out)
//   gen_busy   high in every state except IDLE
//   done       one-cycle pulse on completion (normal or timeout)
//   timeout    one-cycle pulse with done when the drain was aborted
//   cfg_err    one-cycle pulse when a start command is rejected
//   pkt_count  completed-packet counter, wraps at 2^16
// DATA_W must not exceed 16 (payload bytes are taken from the 16-bit LFSR).
module router_pkt_gen #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 2,
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned READ_DLY   = 2,
    parameter int unsigned RD_TIMEOUT = 64,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          dest,
    input  logic [DATA_W-ADDR_W-1:0]   len,
    input  logic                       mode,
    input  logic                       inj_err,
    router_pkt_gen_if.master           rtr,
    output logic                       gen_busy,
    output logic                       done,
    output logic                       timeout,
    output logic                       cfg_err,
    output logic [15:0]                pkt_count
);

    localparam int unsigned LEN_W = DATA_W - ADDR_W;
    localparam int unsigned DLY_W = (READ_DLY > 1) ? $clog2(READ_DLY + 1) : 1;
    localparam int unsigned RD_W  = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_WAIT_RD,
        S_READ,
        S_FINISH
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic               mode_q;
    logic               inj_q;
    logic [NUM_CH-1:0]  ch_mask;
    logic [LEN_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  par_q;
    logic [15:0]        lfsr_q;
    logic [DLY_W-1:0]   dly_cnt;
    logic [RD_W-1:0]    rd_cnt;
    logic               pv_q;
    logic [DATA_W-1:0]  data_q;
    logic [NUM_CH-1:0]  rd_q;

    logic [15:0]        lfsr_adv;
    logic [LEN_W-1:0]   cnt_nxt;
    logic [DATA_W-1:0]  par_nxt;
    logic               drained;

    // Galois LFSR x^16+x^14+x^13+x^11, shifting right
    assign lfsr_adv = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    assign cnt_nxt  = cnt_q + LEN_W'(1);
    // Parity folds in whatever byte is currently on the bus
    assign par_nxt  = par_q ^ data_q;
    assign drained  = (rtr.vld_out & ch_mask) == '0;

    assign rtr.packet_valid = pv_q;
    assign rtr.data_out     = data_q;
    assign rtr.read_enb     = rd_q;

    // Packet sequencer; every output is registered here
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            len_q     <= '0;
            mode_q    <= 1'b0;
            inj_q     <= 1'b0;
            ch_mask   <= '0;
            cnt_q     <= '0;
            par_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            dly_cnt   <= '0;
            rd_cnt    <= '0;
            pv_q      <= 1'b0;
            data_q    <= '0;
            rd_q      <= '0;
            gen_busy  <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            cfg_err   <= 1'b0;
            pkt_count <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            cfg_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len == '0 || 32'(dest) >= NUM_CH) begin
                            cfg_err <= 1'b1;
                        end else begin
                            len_q    <= len;
                            mode_q   <= mode;
                            inj_q    <= inj_err;
                            ch_mask  <= NUM_CH'(1) << dest;
                            cnt_q    <= '0;
                            par_q    <= '0;
                            pv_q     <= 1'b1;
                            data_q   <= {len, dest};
                            gen_busy <= 1'b1;
                            state    <= S_HEADER;
                        end
                    end
                end

                S_HEADER: begin
                    if (!rtr.busy) begin
                        par_q  <= par_nxt;
                        data_q <= mode_q ? '0 : lfsr_q[DATA_W-1:0];
                        state  <= S_PAYLOAD;
                    end
                end

                S_PAYLOAD: begin
                    if (!rtr.busy) begin
                        par_q  <= par_nxt;
                        cnt_q  <= cnt_nxt;
                        lfsr_q <= lfsr_adv;
                        if (cnt_nxt == len_q) begin
                            pv_q   <= 1'b0;
                            data_q <= inj_q ? ~par_nxt : par_nxt;
                            state  <= S_PARITY;
                        end else begin
                            data_q <= mode_q ? DATA_W'(cnt_nxt) : lfsr_adv[DATA_W-1:0];
                        end
                    end
                end

                S_PARITY: begin
                    if (!rtr.busy) begin
                        data_q  <= '0;
                        dly_cnt <= '0;
                        rd_cnt  <= '0;
                        if (READ_DLY == 0) begin
                            rd_q  <= ch_mask;
                            state <= S_READ;
                        end else begin
                            state <= S_WAIT_RD;
                        end
                    end
                end

                S_WAIT_RD: begin
                    if (dly_cnt == DLY_W'(READ_DLY - 1)) begin
                        rd_q  <= ch_mask;
                        state <= S_READ;
                    end else begin
                        dly_cnt <= dly_cnt + DLY_W'(1);
                    end
                end

                S_READ: begin
                    // A drained channel wins over a timeout on the same edge
                    if (drained) begin
                        rd_q      <= '0;
                        done      <= 1'b1;
                        pkt_count <= pkt_count + 16'd1;
                        state     <= S_FINISH;
                    end else if (rd_cnt == RD_W'(RD_TIMEOUT - 1)) begin
                        rd_q      <= '0;
                        done      <= 1'b1;
                        timeout   <= 1'b1;
                        pkt_count <= pkt_count + 16'd1;
                        state     <= S_FINISH;
                    end else begin
                        rd_cnt <= rd_cnt + RD_W'(1);
                    end
                end

                S_FINISH: begin
                    gen_busy <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_gen.sv
// Directed bench for router_pkt_gen. A transaction-level model turns each
// command plus its busy/vld_out pattern into a per-cycle table of expected
// outputs; a negedge process compares the DUT against that table. Literal
// header/parity/count values pin the model.
`timescale 1ns/1ps
module tb_router_pkt_gen;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 2;
    localparam int LEN_W      = 6;
    localparam int NUM_CH     = 3;
    localparam int READ_DLY   = 2;
    localparam int RD_TIMEOUT = 64;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int MAXT = 200;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] dest = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              mode = 1'b0;
    logic              inj_err = 1'b0;
    logic              gen_busy, done, timeout, cfg_err;
    logic [15:0]       pkt_count;

    router_pkt_gen_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) rif ();

    router_pkt_gen #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH),
        .READ_DLY(READ_DLY), .RD_TIMEOUT(RD_TIMEOUT), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .dest(dest), .len(len),
        .mode(mode), .inj_err(inj_err), .rtr(rif), .gen_busy(gen_busy),
        .done(done), .timeout(timeout), .cfg_err(cfg_err), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    // Expected per-cycle outputs of the current transaction
    logic        e_pv   [MAXT];
    logic [7:0]  e_d    [MAXT];
    logic        e_dchk [MAXT];
    logic [2:0]  e_re   [MAXT];
    logic        e_gb   [MAXT];
    logic        e_done [MAXT];
    logic        e_to   [MAXT];
    logic        e_ce   [MAXT];
    logic [15:0] e_pc   [MAXT];
    int          e_kind [MAXT];
    logic        b_pat  [MAXT];
    int          vlow_t;
    logic [2:0]  vmask;

    int          cur_t = 0;
    bit          chk_en = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  obs_hdr, obs_pl0, obs_par;
    int          obs_re_n, obs_to_n, obs_ce_n;
    logic [15:0] lfsr_m = SEED;
    logic [15:0] pc_m = '0;
    int          t_end;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (t=%0d): got 0x%0h, expected 0x%0h", name, cur_t, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic clear_exp(input int d);
        vmask = (d < NUM_CH) ? 3'(1 << d) : 3'b000;
        for (int i = 0; i < MAXT; i++) begin
            e_pv[i] = 1'b0;  e_d[i] = 8'h00;  e_dchk[i] = 1'b0; e_re[i] = 3'b000;
            e_gb[i] = 1'b0;  e_done[i] = 1'b0; e_to[i] = 1'b0;  e_ce[i] = 1'b0;
            e_pc[i] = pc_m;  e_kind[i] = 0;    b_pat[i] = 1'b0;
        end
        vlow_t = 0;
    endtask

    // Build the expected timeline of one legal packet. Cycle 0 carries start;
    // hold = read cycles with vld_out high before it drops.
    task automatic build_pkt(input int d, input int l, input bit m, input bit inj,
                             input int busy_at, input int busy_n, input int hold,
                             output int te);
        logic [7:0] pkt [$];
        logic [7:0] par;
        logic [5:0] l6;
        logic [1:0] d2;
        int t, nread;
        bit to;
        clear_exp(d);
        for (int i = busy_at; i < busy_at + busy_n; i++) b_pat[i] = 1'b1;
        l6 = 6'(l);
        d2 = 2'(d);
        pkt.push_back({l6, d2});
        for (int i = 0; i < l; i++) begin
            pkt.push_back(m ? 8'(i) : lfsr_m[7:0]);
            lfsr_m = lfsr_step(lfsr_m);
        end
        par = 8'h00;
        foreach (pkt[i]) par ^= pkt[i];
        if (inj) par = ~par;
        pkt.push_back(par);
        t = 1;
        foreach (pkt[k]) begin
            // A byte is re-presented every cycle the router is busy
            do begin
                e_pv[t]   = (k < pkt.size() - 1);
                e_d[t]    = pkt[k];
                e_dchk[t] = 1'b1;
                e_kind[t] = (k == 0) ? 1 : (k == 1) ? 2 : (k == pkt.size() - 1) ? 3 : 0;
                t++;
            end while (b_pat[t-1]);
        end
        for (int j = 0; j < READ_DLY; j++) begin
            e_dchk[t] = 1'b1;
            e_d[t]    = 8'h00;
            t++;
        end
        vlow_t = t + hold;
        nread = 0;
        to = 1'b0;
        while (1'b1) begin
            e_re[t] = vmask;
            nread++;
            if (t >= vlow_t) begin t++; break; end
            if (nread == RD_TIMEOUT) begin to = 1'b1; t++; break; end
            t++;
        end
        e_done[t] = 1'b1;
        e_to[t]   = to;
        for (int i = 1; i <= t; i++) e_gb[i] = 1'b1;
        for (int i = t; i < MAXT; i++) e_pc[i] = pc_m + 16'd1;
        pc_m = pc_m + 16'd1;
        te = t + 1;
    endtask

    task automatic build_rej(input int d, output int te);
        clear_exp(d);
        e_ce[1] = 1'b1;
        te = 2;
    endtask

    task automatic run(input int d, input int l, input bit m, input bit inj, input int t_last);
        dest = 2'(d);
        len = 6'(l);
        mode = m;
        inj_err = inj;
        obs_re_n = 0;
        obs_to_n = 0;
        obs_ce_n = 0;
        for (int t = 0; t <= t_last; t++) begin
            cur_t = t;
            start = (t == 0);
            rif.busy = b_pat[t];
            rif.vld_out = (t < vlow_t) ? vmask : 3'b000;
            chk_en = 1'b1;
            @(posedge clk);
            #1;
        end
        chk_en = 1'b0;
        start = 1'b0;
        rif.busy = 1'b0;
        rif.vld_out = 3'b000;
    endtask

    // Cycle-by-cycle comparison against the expected table
    always @(negedge clk) begin
        if (chk_en) begin
            chk("packet_valid", rif.packet_valid, e_pv[cur_t]);
            if (e_dchk[cur_t]) chk("data_out", rif.data_out, e_d[cur_t]);
            chk("read_enb", rif.read_enb, e_re[cur_t]);
            chk("gen_busy", gen_busy, e_gb[cur_t]);
            chk("done", done, e_done[cur_t]);
            chk("timeout", timeout, e_to[cur_t]);
            chk("cfg_err", cfg_err, e_ce[cur_t]);
            chk("pkt_count", pkt_count, e_pc[cur_t]);
            if (e_kind[cur_t] == 1) obs_hdr = rif.data_out;
            if (e_kind[cur_t] == 2) obs_pl0 = rif.data_out;
            if (e_kind[cur_t] == 3) obs_par = rif.data_out;
            if (rif.read_enb != 3'b000) obs_re_n++;
            if (done && timeout) obs_to_n++;
            if (cfg_err) obs_ce_n++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rif.busy = 1'b0;
        rif.vld_out = 3'b000;
        clear_exp(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst packet_valid", rif.packet_valid, 0);
        chk("rst data_out", rif.data_out, 0);
        chk("rst read_enb", rif.read_enb, 0);
        chk("rst gen_busy", gen_busy, 0);
        chk("rst done", done, 0);
        chk("rst timeout", timeout, 0);
        chk("rst cfg_err", cfg_err, 0);
        chk("rst pkt_count", pkt_count, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // 1: dest 0, len 8, incrementing payload
        build_pkt(0, 8, 1'b1, 1'b0, 0, 0, 4, t_end);
        run(0, 8, 1'b1, 1'b0, t_end);
        chk("t1 header", obs_hdr, 8'h20);
        chk("t1 parity", obs_par, 8'h20);
        chk("t1 read cycles", obs_re_n, 5);
        chk("t1 pkt_count", pkt_count, 1);

        // 2: dest 1, len 14, busy for 3 cycles mid-payload
        build_pkt(1, 14, 1'b1, 1'b0, 5, 3, 2, t_end);
        run(1, 14, 1'b1, 1'b0, t_end);
        chk("t2 header", obs_hdr, 8'h39);
        chk("t2 parity", obs_par, 8'h38);
        chk("t2 pkt_count", pkt_count, 2);

        // 3: dest 2, len 17, parity inverted
        build_pkt(2, 17, 1'b1, 1'b1, 0, 0, 3, t_end);
        run(2, 17, 1'b1, 1'b1, t_end);
        chk("t3 header", obs_hdr, 8'h46);
        chk("t3 parity", obs_par, 8'hA9);
        chk("t3 pkt_count", pkt_count, 3);

        // 4: illegal dest, then zero length
        build_rej(3, t_end);
        run(3, 5, 1'b1, 1'b0, t_end);
        chk("t4 cfg_err dest", obs_ce_n, 1);
        build_rej(0, t_end);
        run(0, 0, 1'b1, 1'b0, t_end);
        chk("t4 cfg_err len", obs_ce_n, 1);
        chk("t4 pkt_count", pkt_count, 3);

        // 5: vld_out stuck high, drain aborts after RD_TIMEOUT cycles
        build_pkt(0, 2, 1'b1, 1'b0, 0, 0, 1000, t_end);
        run(0, 2, 1'b1, 1'b0, t_end);
        chk("t5 read cycles", obs_re_n, 64);
        chk("t5 done+timeout", obs_to_n, 1);
        chk("t5 pkt_count", pkt_count, 4);

        // 7: vld_out already low on the first read cycle, LFSR payload
        build_pkt(1, 1, 1'b0, 1'b0, 0, 0, 0, t_end);
        run(1, 1, 1'b0, 1'b0, t_end);
        chk("t7 read cycles", obs_re_n, 1);
        chk("t7 pkt_count", pkt_count, 5);

        // 6: reset in the middle of the payload
        build_pkt(0, 8, 1'b1, 1'b0, 0, 0, 2, t_end);
        run(0, 8, 1'b1, 1'b0, 3);
        chk("t6 pre-reset packet_valid", rif.packet_valid, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6 async packet_valid", rif.packet_valid, 0);
        chk("t6 async data_out", rif.data_out, 0);
        chk("t6 async read_enb", rif.read_enb, 0);
        chk("t6 async gen_busy", gen_busy, 0);
        chk("t6 async pkt_count", pkt_count, 0);
        @(negedge clk);
        chk("t6 done held low", done, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        lfsr_m = SEED;
        pc_m = 16'd0;
        build_pkt(0, 8, 1'b0, 1'b0, 0, 0, 2, t_end);
        run(0, 8, 1'b0, 1'b0, t_end);
        chk("t6 header", obs_hdr, 8'h20);
        chk("t6 first lfsr byte", obs_pl0, 8'hE1);
        chk("t6 pkt_count", pkt_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/router_pkt_gen.md
Name: router_pkt_gen

Overview:
- Synthesizable, parametrised packet source for the 1xN router.
- Replaces fixed per-length stimulus with one engine: builds header/payload/parity from a command, honours router `busy`, then drains the target channel by driving its `read_enb` until `vld_out` drops.
- Sits between a stimulus controller (bench or on-chip BIST) and `router_top`.

Parameters:
- DATA_W, 8: router data byte width.
- ADDR_W, 2: destination field width; header = {len, dest}; LEN_W = DATA_W-ADDR_W (derived localparam).
- NUM_CH, 3: number of router output channels; dest >= NUM_CH is illegal.
- READ_DLY, 2: idle cycles between parity acceptance and first `read_enb` assertion (0 legal).
- RD_TIMEOUT, 64: max cycles `read_enb` is held before abort.
- LFSR_SEED, 16'hACE1: reset value of payload LFSR (must be nonzero).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  command strobe, sampled in IDLE only.
- dest  in  ADDR_W  target channel, captured with start.
- len  in  LEN_W  payload length in bytes, captured with start.
- mode  in  1  payload source: 0 = LFSR, 1 = incrementing from 0.
- inj_err  in  1  when 1, parity byte is inverted; captured with start.
- busy  in  1  router busy.
- vld_out  in  NUM_CH  router per-channel valid.
- packet_valid  out  1  to router.
- data_out  out  DATA_W  to router datain.
- read_enb  out  NUM_CH  per-channel read enable, one-hot or zero.
- gen_busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion (normal or timeout).
- timeout  out  1  one-cycle pulse coincident with done when drain aborted.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- pkt_count  out  16  completed-packet counter, wraps at 2^16.

Behaviour:
- Reset values (async): all outputs 0, state IDLE, LFSR = LFSR_SEED, pkt_count = 0, internal parity = 0.
- FSM states: IDLE, HEADER, PAYLOAD, PARITY, WAIT_RD, READ, FINISH.
- IDLE, start=1:
  - len==0 or dest>=NUM_CH: stay IDLE, pulse cfg_err next cycle.
  - Otherwise: register dest/len/mode/inj_err, clear parity and payload counter, go HEADER.
  - start in any other state is ignored.
- Byte acceptance: a presented byte is accepted on a rising edge where busy==0. While busy==1, data_out and packet_valid hold unchanged.
- HEADER: packet_valid=1, data_out={len,dest}. On accept, parity ^= byte, go PAYLOAD.
- PAYLOAD: packet_valid=1, data_out = LFSR[DATA_W-1:0] (mode 0) or counter value (mode 1).
  - On accept: parity ^= byte; counter++; LFSR advances (x^16+x^14+x^13+x^11 Galois).
  - After len accepted bytes, go PARITY.
  - LFSR state persists across packets and is not reset by start.
- PARITY: packet_valid=0, data_out = parity (inverted if inj_err). On accept, go WAIT_RD.
- WAIT_RD: data_out=0. Count READ_DLY cycles, then go READ.
- READ:
  - read_enb[dest]=1, other bits 0.
  - Exit when vld_out[dest] sampled 0, including on the first READ cycle; deassert read_enb on the next edge and go FINISH.
  - If held RD_TIMEOUT cycles without exit: go FINISH with timeout flagged.
- FINISH: 1 cycle; done=1, timeout as flagged, pkt_count++ (also on timeout); return IDLE.
- Latency: start to first header presentation is 1 cycle; with busy=0 throughout, the parity byte is presented at start+len+2.
- Reset mid-packet: immediate abort, outputs to 0, no done pulse, pkt_count to 0.
- Ownership: `read_enb` never asserted outside READ. `packet_valid` never asserted outside HEADER/PAYLOAD.

Test Plan:
1. Reset → all outputs 0. Then start, dest=0, len=8, mode=1, busy=0 → data_out 0x20, 0x00..0x07, parity 0x20 with packet_valid low. read_enb[0] rises 2 cycles later and holds until vld_out[0]=0. done pulses, pkt_count=1.
2. dest=1, len=14, mode=1; busy forced high 3 cycles mid-payload → bytes held unchanged during busy, no byte skipped or duplicated, header 0x39, parity 0x38, read_enb=3'b010.
3. dest=2, len=17, mode=1, inj_err=1 → header 0x46, parity ~0x56 = 0xA9, read_enb=3'b100.
4. start with dest=3 and, separately, len=0 → cfg_err pulses, gen_busy stays 0, pkt_count unchanged.
5. vld_out[0] stuck high, RD_TIMEOUT=64 → read_enb[0] high exactly 64 cycles, done and timeout pulse together, pkt_count increments.
6. resetn low during PAYLOAD → packet_valid/read_enb drop asynchronously. After release, a new len=8 mode=0 packet's first payload byte equals LFSR_SEED[7:0] (0xE1).
